// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Brief    : Bundle of FETCH, MEM and RAM port signals for mem_port_arbiter.
//             The slave modport is the arbiter's side. The master modport is
//             the pipeline/RAM environment side.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              halt;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;
    logic              stall_if;
    logic              stall_mem;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              idle;

    modport slave (
        input  halt, if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_valid, mem_rdata, mem_valid, stall_if, stall_mem,
               ram_en, ram_we, ram_addr, ram_wdata, idle
    );

    modport master (
        output halt, if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_valid, mem_rdata, mem_valid, stall_if, stall_mem,
               ram_en, ram_we, ram_addr, ram_wdata, idle
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Shares one fixed-latency single-port RAM between the FETCH and
//             MEM pipeline stages. MEM has priority, but FETCH wins once it has
//             lost STARVE_LIMIT grants in a row. FETCH is blocked while halt=1.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int LAT_W = $clog2(LATENCY + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [LAT_W-1:0] C_LAT_LOAD   = LAT_W'(LATENCY);
    localparam logic [LAT_W-1:0] C_LAT_ONE    = LAT_W'(1);
    localparam logic [STV_W-1:0] C_STARVE_MAX = STV_W'(STARVE_LIMIT);
    localparam logic [STV_W-1:0] C_STARVE_ONE = STV_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_IF  = 2'd1,
        ST_BUSY_MEM = 2'd2
    } state_t;

    state_t            r_state;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [STV_W-1:0]  r_starve_cnt;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_if_valid;
    logic              r_mem_valid;

    logic w_arb_slot;
    logic w_if_elig;
    logic w_pick_if;
    logic w_pick_mem;

    // A grant may be issued from IDLE. It may also be issued at the edge that
    // ends a completion cycle, which lets back-to-back accesses run at one per
    // LATENCY+1 cycles. The latency counter reaches zero only in the
    // completion cycle.
    assign w_arb_slot = (r_state == ST_IDLE) || (r_lat_cnt == '0);
    assign w_if_elig  = bus.if_req & ~bus.halt;
    assign w_pick_if  = w_if_elig & (~bus.mem_req | (r_starve_cnt == C_STARVE_MAX));
    assign w_pick_mem = bus.mem_req & ~w_pick_if;

    // Grant, access sequencing, completion pulses and starvation tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_if_valid   <= 1'b0;
            r_mem_valid  <= 1'b0;
        end else begin
            r_ram_en    <= 1'b0;
            r_if_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            if (w_arb_slot) begin
                if (w_pick_if) begin
                    r_state      <= ST_BUSY_IF;
                    r_ram_en     <= 1'b1;
                    r_ram_we     <= 1'b0;
                    r_ram_addr   <= bus.if_addr;
                    r_lat_cnt    <= C_LAT_LOAD;
                    r_starve_cnt <= '0;
                end else if (w_pick_mem) begin
                    r_state     <= ST_BUSY_MEM;
                    r_ram_en    <= 1'b1;
                    r_ram_we    <= bus.mem_we;
                    r_ram_addr  <= bus.mem_addr;
                    r_ram_wdata <= bus.mem_wdata;
                    r_lat_cnt   <= C_LAT_LOAD;
                    if (w_if_elig && (r_starve_cnt != C_STARVE_MAX)) begin
                        r_starve_cnt <= r_starve_cnt + C_STARVE_ONE;
                    end
                end else begin
                    r_state <= ST_IDLE;
                end
            end else begin
                r_lat_cnt <= r_lat_cnt - C_LAT_ONE;
                // The count is about to reach zero, so the next cycle is the
                // one in which the RAM data is valid.
                if (r_lat_cnt == C_LAT_ONE) begin
                    r_if_valid  <= (r_state == ST_BUSY_IF);
                    r_mem_valid <= (r_state == ST_BUSY_MEM);
                end
            end
        end
    end

    assign bus.ram_en    = r_ram_en;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.mem_valid = r_mem_valid;
    assign bus.if_rdata  = bus.ram_rdata;
    assign bus.mem_rdata = bus.ram_rdata;
    assign bus.stall_if  = bus.if_req & ~r_if_valid;
    assign bus.stall_mem = bus.mem_req & ~r_mem_valid;
    assign bus.idle      = (r_state == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Self-checking bench for mem_port_arbiter. It uses a transaction
//             level reference model, directed scenarios and random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam int SL  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .STARVE_LIMIT(SL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Environment RAM: the read data appears LAT cycles after the strobe cycle.
    // When no read is returning, the data lines carry junk.
    logic [DW-1:0] ram  [256];
    logic [DW-1:0] pipe [LAT];
    always @(posedge clk) begin
        logic [DW-1:0] nd;
        nd = bus.ram_en ? ram[bus.ram_addr] : DW'($urandom);
        if (bus.ram_en && bus.ram_we) ram[bus.ram_addr] = bus.ram_wdata;
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = nd;
        bus.ram_rdata <= pipe[LAT-1];
    end

    // Reference model: tracks when the port becomes free, who owns the
    // current access and what data that access must return.
    logic [DW-1:0] shadow [256];
    int free_at, done_at, own, starve;
    logic          e_ram_en, e_we, e_ifv, e_memv, e_idle, e_load;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_data;

    always @(posedge clk) begin
        logic s_ifr, s_halt, s_memr, s_we;
        logic [AW-1:0] s_ia, s_ma;
        logic [DW-1:0] s_wd;
        cyc++;
        s_ifr = bus.if_req;  s_halt = bus.halt; s_ia = bus.if_addr;
        s_memr = bus.mem_req; s_we = bus.mem_we; s_ma = bus.mem_addr; s_wd = bus.mem_wdata;
        if (!rst_n) begin
            free_at = 0; done_at = -1; own = 0; starve = 0;
            e_ram_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
            e_ifv = 0; e_memv = 0; e_idle = 1; e_load = 0; e_data = '0;
        end else begin
            e_ifv    = (own == 1) && (cyc == done_at);
            e_memv   = (own == 2) && (cyc == done_at);
            e_ram_en = 1'b0;
            if (cyc >= free_at) begin
                if (s_ifr && !s_halt && (!s_memr || starve >= SL)) begin
                    own = 1; e_ram_en = 1; e_addr = s_ia; e_we = 0; starve = 0;
                    e_data = shadow[s_ia];
                end else if (s_memr) begin
                    own = 2; e_ram_en = 1; e_addr = s_ma; e_we = s_we; e_wdata = s_wd;
                    e_load = !s_we;
                    if (s_ifr && !s_halt && starve < SL) starve++;
                    if (s_we) shadow[s_ma] = s_wd;
                    else      e_data = shadow[s_ma];
                end
                if (e_ram_en) begin
                    done_at = cyc + LAT;
                    free_at = cyc + LAT + 1;
                end
            end
            e_idle = (cyc >= free_at);
        end
        #1;
        if (rst_n && chk_on) begin
            chk("ram_en",    32'(bus.ram_en),    32'(e_ram_en));
            chk("ram_we",    32'(bus.ram_we),    32'(e_we));
            chk("ram_addr",  32'(bus.ram_addr),  32'(e_addr));
            chk("ram_wdata", 32'(bus.ram_wdata), 32'(e_wdata));
            chk("if_valid",  32'(bus.if_valid),  32'(e_ifv));
            chk("mem_valid", 32'(bus.mem_valid), 32'(e_memv));
            chk("idle",      32'(bus.idle),      32'(e_idle));
            chk("stall_if",  32'(bus.stall_if),  32'(bus.if_req & ~e_ifv));
            chk("stall_mem", 32'(bus.stall_mem), 32'(bus.mem_req & ~e_memv));
            if (e_ifv)           chk("if_rdata",  32'(bus.if_rdata),  32'(e_data));
            if (e_memv && e_load) chk("mem_rdata", 32'(bus.mem_rdata), 32'(e_data));
        end
    end

    // Waits (bounded) for ram_en (0), if_valid (1) or mem_valid (2) at a negedge
    task automatic wait_sig(input int which, output int at);
        at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((which == 0 && bus.ram_en) || (which == 1 && bus.if_valid) ||
                (which == 2 && bus.mem_valid)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            total++;
            bad++;
            $display("FAIL wait_%0d: event not seen, got 0 required 1", which);
        end
    endtask

    initial begin
        int g, v, g2, v2, n, ens;
        int gaddr [6];
        int exp3  [6];
        exp3 = '{32'h64, 32'h64, 32'h64, 32'h64, 32'h02, 32'h64};
        for (int i = 0; i < 256; i++) begin
            ram[i]    = DW'(i * 263) ^ 16'h5A5A;
            shadow[i] = ram[i];
        end
        ram[8'h10] = 16'hA123; shadow[8'h10] = 16'hA123;
        ram[8'h30] = 16'h3C3C; shadow[8'h30] = 16'h3C3C;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        bus.halt = 0; bus.if_req = 0; bus.if_addr = '0;
        bus.mem_req = 0; bus.mem_we = 0; bus.mem_addr = '0; bus.mem_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_ram_en",    32'(bus.ram_en),    32'd0);
        chk("rst_if_valid",  32'(bus.if_valid),  32'd0);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_idle",      32'(bus.idle),      32'd1);
        chk("rst_ram_addr",  32'(bus.ram_addr),  32'd0);
        rst_n  = 1;
        chk_on = 1;
        @(negedge clk);

        // FETCH only
        bus.if_req = 1; bus.if_addr = 8'h10;
        wait_sig(0, g);
        chk("t1_addr", 32'(bus.ram_addr), 32'h10);
        chk("t1_stall", 32'(bus.stall_if), 32'd1);
        wait_sig(1, v);
        chk("t1_latency", 32'(v - g), 32'd2);
        chk("t1_rdata", 32'(bus.if_rdata), 32'hA123);
        bus.if_req = 0;
        @(negedge clk);

        // Simultaneous FETCH and MEM: MEM first, FETCH on the edge after mem_valid
        bus.if_req = 1; bus.if_addr = 8'h02;
        bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 8'h64;
        wait_sig(0, g);
        chk("t2_first", 32'(bus.ram_addr), 32'h64);
        wait_sig(2, v);
        bus.mem_req = 0;
        wait_sig(0, g2);
        chk("t2_second", 32'(bus.ram_addr), 32'h02);
        chk("t2_gap", 32'(g2 - v), 32'd1);
        wait_sig(1, v2);
        bus.if_req = 0;
        @(negedge clk);

        // Starvation bound: MEM held continuously
        bus.if_req = 1; bus.if_addr = 8'h02;
        bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 8'h64;
        n = 0;
        for (int k = 0; k < 60 && n < 6; k++) begin
            @(negedge clk);
            if (bus.ram_en) begin
                gaddr[n] = 32'(bus.ram_addr);
                n++;
            end
            if (bus.if_valid) bus.if_req = 0;
        end
        chk("t3_count", 32'(n), 32'd6);
        for (int k = 0; k < 6; k++) chk("t3_order", 32'(gaddr[k]), 32'(exp3[k]));
        wait_sig(2, v);
        bus.mem_req = 0;
        @(negedge clk);

        // Store
        bus.mem_req = 1; bus.mem_we = 1; bus.mem_addr = 8'h68; bus.mem_wdata = 16'h0005;
        wait_sig(0, g);
        chk("t4_we", 32'(bus.ram_we), 32'd1);
        chk("t4_addr", 32'(bus.ram_addr), 32'h68);
        chk("t4_wdata", 32'(bus.ram_wdata), 32'h0005);
        wait_sig(2, v);
        chk("t4_latency", 32'(v - g), 32'd2);
        chk("t4_if_valid", 32'(bus.if_valid), 32'd0);
        bus.mem_req = 0; bus.mem_we = 0;
        @(negedge clk);

        // halt raised during a FETCH access
        bus.if_req = 1; bus.if_addr = 8'h20;
        wait_sig(0, g);
        bus.halt = 1;
        wait_sig(1, v);
        chk("t5_latency", 32'(v - g), 32'd2);
        bus.if_addr = 8'h21;
        ens = 0;
        repeat (8) begin
            @(negedge clk);
            ens += int'(bus.ram_en);
        end
        chk("t5_no_grant", 32'(ens), 32'd0);
        chk("t5_idle", 32'(bus.idle), 32'd1);
        chk("t5_stall", 32'(bus.stall_if), 32'd1);
        bus.if_req = 0; bus.halt = 0;
        @(negedge clk);

        // Reset one cycle after a grant
        bus.if_req = 1; bus.if_addr = 8'h30;
        wait_sig(0, g);
        rst_n = 0;
        #1;
        chk("t6_ram_en", 32'(bus.ram_en), 32'd0);
        chk("t6_if_valid", 32'(bus.if_valid), 32'd0);
        chk("t6_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("t6_idle", 32'(bus.idle), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        wait_sig(0, g);
        wait_sig(1, v);
        chk("t6_latency", 32'(v - g), 32'd2);
        chk("t6_rdata", 32'(bus.if_rdata), 32'h3C3C);
        bus.if_req = 0;
        @(negedge clk);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!(bus.if_req && !bus.if_valid)) begin
                bus.if_req  = ($urandom_range(0, 3) != 0);
                bus.if_addr = AW'($urandom_range(0, 31));
            end else if ($urandom_range(0, 31) == 0) begin
                bus.if_req = 0;
            end
            if (!(bus.mem_req && !bus.mem_valid)) begin
                bus.mem_req   = ($urandom_range(0, 2) != 0);
                bus.mem_we    = ($urandom_range(0, 2) == 0);
                bus.mem_addr  = AW'($urandom_range(0, 31));
                bus.mem_wdata = DW'($urandom);
            end else if ($urandom_range(0, 31) == 0) begin
                bus.mem_req = 0;
            end
            if ($urandom_range(0, 15) == 0) bus.halt = ~bus.halt;
        end
        @(negedge clk);
        bus.if_req = 0; bus.mem_req = 0; bus.halt = 0;
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
